fht_input_loader: RTL
=====================

// Module: fht_input_loader
// PURPOSE
//  Upstream stage of fht_control. Accepts a stream of time-domain samples via valid/ready,
//  writes one frame of N_POINT samples into the 4 FHT data banks (bit-reversed order),
//  then pulses the FHT start and holds off the next frame until the FHT reports ready again.
// PARAMETERS
//  N_POINT  1024  frame length; power of 2, >= 16
//  LOG2_N   10    log2(N_POINT)
//  A_BIT    8     bank address width = LOG2_N - 2 (bank depth N_POINT/4)
//  D_BIT    16    sample width
// PORTS
//  iCLK        in   1      clock; all logic on posedge
//  iRESET      in   1      asynchronous, active-high reset
//  iDATA       in   D_BIT  input sample
//  iVALID      in   1      iDATA valid
//  oREADY      out  1      loader accepts a sample this cycle
//  oDATA       out  D_BIT  write data to banks (registered)
//  oADDR_WR    out  A_BIT  write address inside selected bank (registered)
//  oWE         out  4      one-hot bank write enable, bank b = oWE[b] (registered)
//  oSTART_FHT  out  1      one-cycle start pulse to fht_control iSTART
//  iFHT_RDY    in   1      fht_control oRDY (0 = transform running)
//  oFRAME_CNT  out  8      completed frames, wraps 255 -> 0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, sample cnt k=0, oREADY=0, oWE=0, oDATA=0,
//   oADDR_WR=0, oSTART_FHT=0, oFRAME_CNT=0. Reset mid-frame discards partial frame,
//   no start pulse is issued; on release loading restarts at k=0.
//  FSM: IDLE -> LOAD (unconditional, 1 cycle after reset release).
//   LOAD: oREADY=1 (comb. from state). Accept = iVALID & oREADY. Each accept: k++;
//    accept with k==N_POINT-1 -> START, k<=0.
//   START: oREADY=0; oSTART_FHT=1 for exactly this cycle -> WAIT_BUSY.
//   WAIT_BUSY: wait iFHT_RDY==0 -> WAIT_DONE. (Ignores iFHT_RDY==1 seen same cycle as pulse.)
//   WAIT_DONE: wait iFHT_RDY==1 -> LOAD; oFRAME_CNT++ on this transition.
//  Address map: r = bitrev_LOG2N(k) (see CONFIGURATION); bank = r[1:0], oADDR_WR = r[LOG2_N-1:2].
//  Latency: sample accepted at edge t appears on oDATA/oADDR_WR/oWE during cycle t+1;
//   oWE=0 in any cycle without a preceding accept. Exactly N_POINT writes per frame.
//  Last write (k=N_POINT-1) occurs in the START cycle, same cycle as oSTART_FHT;
//   fht_control first reads >= 1 cycle later, so data is in RAM before use.
//  iVALID low inside LOAD: stall, no write, k unchanged. iVALID in non-LOAD states: ignored,
//   sample not consumed (upstream holds it).
//  iDATA is captured only on accept; no combinational path iVALID -> oREADY.
//  k is LOG2_N bits; never exceeds N_POINT-1 (no wrap beyond frame).
// CONFIGURATION
//  FHT_LOADER_BITREV_EN defined: r = bit-reversed k (LOG2_N bits) -> in-place radix FHT order.
//  Not defined: r = k (natural order; for external pre-permuted streams / debug dumps).
//  Both variants: identical FSM, handshake, latency and port list.
// TESTING (bench at N_POINT=16, LOG2_N=4, A_BIT=2, BITREV_EN defined unless noted)
//  1 Reset: hold iRESET=1 3 cycles -> all outputs 0; oREADY=1 on 2nd edge after release.
//  2 Stream k=0..15 iVALID=1 constant, iDATA=100+k -> k=1 writes 101 to bank0 addr2,
//    k=2 bank0 addr1, k=3 bank0 addr3, k=15 bank3 addr3; 16 writes, each bank 4 times;
//    oSTART_FHT single pulse in cycle of 16th write; oREADY=0 from that cycle.
//  3 Hold off: after start keep iFHT_RDY=1 10 cycles, then 0 for 50, then 1 ->
//    oREADY stays 0 throughout, rises 1 cycle after iFHT_RDY returns 1; oFRAME_CNT=1.
//  4 Stalls: random iVALID (~50% duty) -> same bank/addr/data map as scenario 2,
//    no write in stalled cycles, exactly one start pulse.
//  5 Reset at k=7 then full frame -> no start before 16 new accepts; first write is k=0, data
//    from post-reset stream; oFRAME_CNT=0 until that frame completes.
//  6 BITREV_EN undefined, scenario 2 stimulus -> k=5 goes bank1 addr1, k=14 bank2 addr3.

Source files
------------

// File: rtl/fht_input_loader.sv
// Frame loader feeding the 4 FHT data banks from a valid/ready sample stream.
// Define FHT_LOADER_BITREV_EN for bit-reversed bank addressing (natural order otherwise).
module fht_input_loader #(
    parameter int N_POINT = 1024,
    parameter int LOG2_N  = 10,
    parameter int A_BIT   = 8,
    parameter int D_BIT   = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-1:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [3:0]       oWE,
    output logic             oSTART_FHT,
    input  logic             iFHT_RDY,
    output logic [7:0]       oFRAME_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [LOG2_N-1:0] K_LAST = LOG2_N'(N_POINT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [LOG2_N-1:0] k;
    logic [LOG2_N-1:0] r;
    logic              accept;
    logic              last;

    assign accept = iVALID & oREADY;
    assign last   = (k == K_LAST);

    // Map sample index to bank position (bank in low bits, address above)
    always_comb begin
`ifdef FHT_LOADER_BITREV_EN
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = k[LOG2_N-1-i];
        end
`else
        r = k;
`endif
    end

    // State register
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      state_nxt = LOAD;
            LOAD:      if (accept && last) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!iFHT_RDY) state_nxt = WAIT_DONE;
            WAIT_DONE: if (iFHT_RDY) state_nxt = LOAD;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake and start pulse decoded purely from state
    always_comb begin
        oREADY     = (state == LOAD);
        oSTART_FHT = (state == START);
    end

    // Sample counter and registered bank write port
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            k        <= '0;
            oDATA    <= '0;
            oADDR_WR <= '0;
            oWE      <= '0;
        end else if (accept) begin
            k        <= last ? '0 : k + 1'b1;
            oDATA    <= iDATA;
            oADDR_WR <= r[LOG2_N-1:2];
            oWE      <= 4'b0001 << r[1:0];
        end else begin
            oWE      <= '0;
        end
    end

    // Completed-frame counter, bumped when the FHT hands control back
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oFRAME_CNT <= '0;
        end else if (state == WAIT_DONE && iFHT_RDY) begin
            oFRAME_CNT <= oFRAME_CNT + 8'd1;
        end
    end

endmodule
